main_bus_arbiter: RTL and testbench

- Two-master arbiter for the single-ported main bus memory.
- Lets the CPU core and a second requester (boot loader / debug port) share one memory port.
- Round-robin grant with a bus lock, so read-modify-write sequences (sub-word stores) stay atomic.
- Supports pipelined issue, with the fixed memory latency tracked by a tagged response shift register.

---
 rtl/main_bus_pkg.sv | 24 ++
 rtl/main_bus_arbiter_if.sv | 27 ++
 rtl/bus_rsp_tracker.sv | 44 ++++
 rtl/main_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_main_bus_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/main_bus_pkg.sv
// Shared types and constants for the main bus arbiter and its response tracker.
package main_bus_pkg;

  // Arbiter ownership states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  // One slot of the read-response shift register: owner 0 = CPU, 1 = secondary.
  typedef struct packed {
    logic valid;
    logic owner;
  } rsp_tag_t;

  // Word-access mask: memory never sees byte-offset bits.
  localparam logic [31:0] MEM_ADDR_ALIGN = 32'hFFFF_FFFC;

  function automatic logic [31:0] align_addr(input logic [31:0] addr);
    return addr & MEM_ADDR_ALIGN;
  endfunction

endpackage

// File: rtl/main_bus_arbiter_if.sv
// Per-master request/response bundle for the main bus arbiter.
//
// Handshake: a beat transfers in any cycle where valid and ready are both
// high. Once valid is raised the master keeps valid, write, addr, wdata and
// lock stable until ready is seen. lock asks the arbiter to keep the grant
// after this beat. rvalid pulses for one cycle with rdata for every
// accepted read; rdata is zero whenever rvalid is low.
interface main_bus_arbiter_if;
  logic        valid;
  logic        write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        lock;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output valid, write, addr, wdata, lock,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, write, addr, wdata, lock,
    output ready, rvalid, rdata
  );
endinterface

// File: rtl/bus_rsp_tracker.sv
// Tagged read-response shift register. Every accepted read pushes its owner
// tag; after MEM_LATENCY cycles the tag reaches the tail, where mem_rdata is
// steered to that owner and its rvalid pulses for one cycle.
module bus_rsp_tracker
  import main_bus_pkg::*;
#(
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        push_owner,
  input  logic [31:0] mem_rdata,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1
);

  rsp_tag_t [MEM_LATENCY-1:0] pipe;
  rsp_tag_t                   tail;

  // Shift one slot per cycle; reset drops anything still in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= '{valid: push, owner: push_owner};
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  // Route the memory data to the tagged master only; the other sees zero.
  always_comb begin
    tail    = pipe[MEM_LATENCY-1];
    rvalid0 = tail.valid & ~tail.owner;
    rvalid1 = tail.valid & tail.owner;
    rdata0  = rvalid0 ? mem_rdata : '0;
    rdata1  = rvalid1 ? mem_rdata : '0;
  end

endmodule

// File: rtl/main_bus_arbiter.sv
// Two-master round-robin arbiter for the single-ported main bus memory.
// Master 0 is the CPU, master 1 the boot loader / debug port. The owner may
// hold the grant with lock so read-modify-write sequences stay atomic.
// Optional lock watchdog: define BUS_ARB_WATCHDOG_EN to break locks held for
// LOCK_TIMEOUT consecutive cycles and raise the sticky lock_err flag.
module main_bus_arbiter
  import main_bus_pkg::*;
#(
  parameter int MEM_LATENCY  = 2,
  parameter int LOCK_TIMEOUT = 64
) (
  input  logic                cpu_clk,
  input  logic                rst,
  main_bus_arbiter_if.slave   m0,
  main_bus_arbiter_if.slave   m1,
  output logic                mem_re,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  output logic                lock_err,
  output arb_state_t          dbg_state
);

  arb_state_t  state;
  logic        last_served;
  logic        own0;
  logic        own1;
  logic        beat;
  logic        beat_write;
  logic [31:0] beat_addr;
  logic [31:0] beat_wdata;
  logic        owner_lock;
  logic        lock_eff;
  logic        rv0;
  logic        rv1;
  logic [31:0] rd0;
  logic [31:0] rd1;

  assign dbg_state = state;

  // Grant decode and memory-side beat mux; an accepted beat drives mem_* this cycle.
  always_comb begin
    own0       = (state == ST_OWN0);
    own1       = (state == ST_OWN1);
    m0.ready   = own0 & m0.valid;
    m1.ready   = own1 & m1.valid;
    beat       = m0.ready | m1.ready;
    beat_write = own1 ? m1.write : m0.write;
    beat_addr  = own1 ? m1.addr  : m0.addr;
    beat_wdata = own1 ? m1.wdata : m0.wdata;
    owner_lock = (own0 & m0.lock) | (own1 & m1.lock);
    mem_re     = beat & ~beat_write;
    mem_we     = beat & beat_write;
    mem_addr   = beat ? align_addr(beat_addr) : '0;
    mem_wdata  = mem_we ? beat_wdata : '0;
  end

`ifdef BUS_ARB_WATCHDOG_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  logic [CW-1:0] lock_cnt;
  logic          lock_timeout;

  // The cycle that would be the LOCK_TIMEOUT-th consecutive locked cycle is
  // treated as unlocked, so the owner is released at the end of it.
  assign lock_timeout = owner_lock && (lock_cnt == CW'(LOCK_TIMEOUT - 1));
  assign lock_eff     = owner_lock & ~lock_timeout;

  // Count consecutive locked-owner cycles; latch the sticky error on expiry.
  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      lock_cnt <= '0;
      lock_err <= 1'b0;
    end else begin
      lock_cnt <= lock_eff ? lock_cnt + 1'b1 : '0;
      if (lock_timeout) begin
        lock_err <= 1'b1;
      end
    end
  end
`else
  logic unused_timeout;

  assign unused_timeout = (LOCK_TIMEOUT > 0);
  assign lock_eff       = owner_lock;
  assign lock_err       = 1'b0;
`endif

  // Ownership FSM with the round-robin last-served pointer.
  always_ff @(posedge cpu_clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      last_served <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (m0.valid && m1.valid) begin
            state <= last_served ? ST_OWN0 : ST_OWN1;
          end else if (m0.valid) begin
            state <= ST_OWN0;
          end else if (m1.valid) begin
            state <= ST_OWN1;
          end
        end
        ST_OWN0: begin
          if (!(m0.valid || lock_eff)) begin
            last_served <= 1'b0;
            state       <= m1.valid ? ST_OWN1 : ST_IDLE;
          end
        end
        ST_OWN1: begin
          if (!(m1.valid || lock_eff)) begin
            last_served <= 1'b1;
            state       <= m0.valid ? ST_OWN0 : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  bus_rsp_tracker #(
    .MEM_LATENCY (MEM_LATENCY)
  ) u_rsp (
    .clk        (cpu_clk),
    .rst        (rst),
    .push       (mem_re),
    .push_owner (own1),
    .mem_rdata  (mem_rdata),
    .rvalid0    (rv0),
    .rvalid1    (rv1),
    .rdata0     (rd0),
    .rdata1     (rd1)
  );

  assign m0.rvalid = rv0;
  assign m0.rdata  = rd0;
  assign m1.rvalid = rv1;
  assign m1.rdata  = rd1;

endmodule

// File: tb/tb_main_bus_arbiter.sv
// Directed bench for main_bus_arbiter (MEM_LATENCY=2, LOCK_TIMEOUT=64).
// Works with and without BUS_ARB_WATCHDOG_EN defined.
module tb_main_bus_arbiter;
  import main_bus_pkg::*;

  localparam logic T = 1'b1;
  localparam logic F = 1'b0;

  // ---------------- clock / reset ----------------
  logic cpu_clk = 1'b0;
  logic rst     = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  main_bus_arbiter_if m0_if ();
  main_bus_arbiter_if m1_if ();

  logic        mem_re;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        lock_err;
  arb_state_t  dbg_state;

  main_bus_arbiter #(
    .MEM_LATENCY  (2),
    .LOCK_TIMEOUT (64)
  ) dut (
    .cpu_clk   (cpu_clk),
    .rst       (rst),
    .m0        (m0_if),
    .m1        (m1_if),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .lock_err  (lock_err),
    .dbg_state (dbg_state)
  );

  // ---------------- vector types ----------------
  typedef struct packed {
    logic        r0;
    logic        r1;
    logic        re;
    logic        we;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        rv0;
    logic        rv1;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } out_t;

  typedef struct packed {
    logic        v0;
    logic        w0;
    logic [31:0] a0;
    logic [31:0] d0;
    logic        v1;
    logic [31:0] a1;
    logic [31:0] mrd;
    out_t        exp;
  } vec_t;

  function automatic vec_t mkv(
    input logic v0, w0, input logic [31:0] a0, d0,
    input logic v1, input logic [31:0] a1, mrd,
    input logic r0, r1, re, we, input logic [31:0] maddr, mwd,
    input logic rv0, rv1, input logic [31:0] rd0, rd1);
    vec_t v;
    v.v0 = v0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.v1 = v1; v.a1 = a1; v.mrd = mrd;
    v.exp.r0 = r0; v.exp.r1 = r1; v.exp.re = re; v.exp.we = we;
    v.exp.maddr = maddr; v.exp.mwd = mwd;
    v.exp.rv0 = rv0; v.exp.rv1 = rv1; v.exp.rd0 = rd0; v.exp.rd1 = rd1;
    return v;
  endfunction

  function automatic out_t cur_out();
    out_t o;
    o.r0 = m0_if.ready; o.r1 = m1_if.ready;
    o.re = mem_re; o.we = mem_we;
    o.maddr = mem_addr; o.mwd = mem_wdata;
    o.rv0 = m0_if.rvalid; o.rv1 = m1_if.rvalid;
    o.rd0 = m0_if.rdata; o.rd1 = m1_if.rdata;
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input out_t act, input out_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_m0(input logic v, w, input logic [31:0] a, d, input logic l);
    m0_if.valid = v; m0_if.write = w; m0_if.addr = a; m0_if.wdata = d; m0_if.lock = l;
  endtask

  task automatic set_m1(input logic v, w, input logic [31:0] a, d, input logic l);
    m1_if.valid = v; m1_if.write = w; m1_if.addr = a; m1_if.wdata = d; m1_if.lock = l;
  endtask

  // Inputs change 1 time unit after the rising edge; checks run 3 units later.
  task automatic next_cycle();
    @(posedge cpu_clk);
    #1;
  endtask

  localparam logic [31:0] JUNK = 32'h0BAD_F00D;

  vec_t vecs [16];
  out_t zero_out;
  int   granted_at;

  initial begin
    zero_out  = '0;
    mem_rdata = JUNK;
    set_m0(F, F, 0, 0, F);
    set_m1(F, F, 0, 0, F);

    // Cycle-by-cycle table: tie after reset, handover bubbles, second tie,
    // unaligned address, then a single CPU read followed by a write.
    vecs[0]  = mkv(T,F,'h100,0,     T,'h200, JUNK,        F,F,F,F,0,0,             F,F,0,0);
    vecs[1]  = mkv(T,F,'h100,0,     T,'h200, JUNK,        T,F,T,F,'h100,0,         F,F,0,0);
    vecs[2]  = mkv(F,F,0,0,         T,'h200, JUNK,        F,F,F,F,0,0,             F,F,0,0);
    vecs[3]  = mkv(F,F,0,0,         T,'h200, 'hA0000001,  F,T,T,F,'h200,0,         T,F,'hA0000001,0);
    vecs[4]  = mkv(F,F,0,0,         F,0,     JUNK,        F,F,F,F,0,0,             F,F,0,0);
    vecs[5]  = mkv(T,F,'h104,0,     T,'h20B, 'hB0000002,  F,F,F,F,0,0,             F,T,0,'hB0000002);
    vecs[6]  = mkv(T,F,'h104,0,     T,'h20B, JUNK,        T,F,T,F,'h104,0,         F,F,0,0);
    vecs[7]  = mkv(F,F,0,0,         T,'h20B, JUNK,        F,F,F,F,0,0,             F,F,0,0);
    vecs[8]  = mkv(F,F,0,0,         T,'h20B, 'hC0000003,  F,T,T,F,'h208,0,         T,F,'hC0000003,0);
    vecs[9]  = mkv(F,F,0,0,         F,0,     JUNK,        F,F,F,F,0,0,             F,F,0,0);
    vecs[10] = mkv(F,F,0,0,         F,0,     'hD0000004,  F,F,F,F,0,0,             F,T,0,'hD0000004);
    vecs[11] = mkv(T,F,'h10000,0,   F,0,     JUNK,        F,F,F,F,0,0,             F,F,0,0);
    vecs[12] = mkv(T,F,'h10000,0,   F,0,     JUNK,        T,F,T,F,'h10000,0,       F,F,0,0);
    vecs[13] = mkv(T,T,'h10008,'h12345678, F,0, JUNK,     T,F,F,T,'h10008,'h12345678, F,F,0,0);
    vecs[14] = mkv(F,F,0,0,         F,0,     'hCAFE0001,  F,F,F,F,0,0,             T,F,'hCAFE0001,0);
    vecs[15] = mkv(F,F,0,0,         F,0,     'h55555555,  F,F,F,F,0,0,             F,F,0,0);

    // ---------------- reset state ----------------
    repeat (3) @(posedge cpu_clk);
    #1;
    chk_out("reset_outputs", cur_out(), zero_out);
    chk1("reset_state_idle", dbg_state == ST_IDLE, T);
    chk1("reset_lock_err", lock_err, F);
    next_cycle();
    rst = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 16; i++) begin
      set_m0(vecs[i].v0, vecs[i].w0, vecs[i].a0, vecs[i].d0, F);
      set_m1(vecs[i].v1, F, vecs[i].a1, 0, F);
      mem_rdata = vecs[i].mrd;
      #3;
      chk_out($sformatf("vec%0d", i), cur_out(), vecs[i].exp);
      next_cycle();
    end

    // ---------------- locked RMW, m1 waiting ----------------
    mem_rdata = JUNK;
    set_m0(T, F, 'h10004, 0, T);
    #3; chk1("lock_l0_ready0", m0_if.ready, F);
    next_cycle();
    set_m1(T, T, 'h300, 'h99, F);
    #3;
    chk1("lock_l1_ready0", m0_if.ready, T);
    chk32("lock_l1_addr", mem_addr, 'h10004);
    chk1("lock_l1_ready1", m1_if.ready, F);
    next_cycle();
    set_m0(F, F, 0, 0, T);
    for (int k = 2; k <= 4; k++) begin
      mem_rdata = (k == 3) ? 32'h0000_BEEF : JUNK;
      #3;
      chk1($sformatf("lock_l%0d_ready1", k), m1_if.ready, F);
      chk1($sformatf("lock_l%0d_mem_we", k), mem_we, F);
      if (k == 3) chk32("lock_l3_rdata0", m0_if.rdata, 'h0000_BEEF);
      next_cycle();
    end
    mem_rdata = JUNK;
    set_m0(T, T, 'h10004, 'h5A, F);
    #3;
    chk1("lock_l5_ready0", m0_if.ready, T);
    chk32("lock_l5_wdata", mem_wdata, 'h5A);
    chk1("lock_l5_ready1", m1_if.ready, F);
    next_cycle();
    set_m0(F, F, 0, 0, F);
    #3; chk1("lock_l6_bubble", m1_if.ready, F);
    next_cycle();
    #3;
    chk1("lock_l7_ready1", m1_if.ready, T);
    chk32("lock_l7_addr", mem_addr, 'h300);
    chk32("lock_l7_wdata", mem_wdata, 'h99);
    next_cycle();
    set_m1(F, F, 0, 0, F);
    next_cycle();
    next_cycle();

    // ---------------- m1 back-to-back reads, handover to CPU ----------------
    set_m1(T, F, 'h200, 0, F);
    #3; chk1("b2b_p0_ready1", m1_if.ready, F);
    next_cycle();
    #3; chk32("b2b_p1_addr", mem_addr, 'h200);
    next_cycle();
    set_m1(T, F, 'h204, 0, F);
    set_m0(T, F, 'h400, 0, F);
    #3;
    chk1("b2b_p2_ready1", m1_if.ready, T);
    chk32("b2b_p2_addr", mem_addr, 'h204);
    chk1("b2b_p2_ready0", m0_if.ready, F);
    next_cycle();
    set_m1(F, F, 0, 0, F);
    mem_rdata = 'hE100_0001;
    #3;
    chk1("b2b_p3_bubble", m0_if.ready, F);
    chk32("b2b_p3_rdata1", m1_if.rdata, 'hE100_0001);
    chk1("b2b_p3_rvalid0", m0_if.rvalid, F);
    next_cycle();
    mem_rdata = 'hE200_0002;
    #3;
    chk1("b2b_p4_ready0", m0_if.ready, T);
    chk32("b2b_p4_rdata1", m1_if.rdata, 'hE200_0002);
    chk1("b2b_p4_rvalid1", m1_if.rvalid, T);
    chk1("b2b_p4_rvalid0", m0_if.rvalid, F);
    next_cycle();
    set_m0(F, F, 0, 0, F);
    mem_rdata = JUNK;
    next_cycle();
    #3; chk1("b2b_p6_rvalid0", m0_if.rvalid, T);
    next_cycle();
    next_cycle();

    // ---------------- lock watchdog ----------------
    set_m0(T, F, 'h600, 0, T);
    next_cycle();
    set_m1(T, F, 'h500, 0, F);
    #3; chk1("wd_accept_ready0", m0_if.ready, T);
    next_cycle();
    set_m0(F, F, 0, 0, T);
    granted_at = 0;
    for (int k = 1; k <= 100; k++) begin
      #3;
      if (m1_if.ready) begin
        granted_at = k;
        break;
      end
      next_cycle();
    end
`ifdef BUS_ARB_WATCHDOG_EN
    chk32("wd_grant_cycle", granted_at, 64);
    chk1("wd_lock_err_set", lock_err, T);
    next_cycle();
    set_m1(F, F, 0, 0, F);
    set_m0(F, F, 0, 0, F);
    repeat (4) next_cycle();
    #3; chk1("wd_lock_err_sticky", lock_err, T);
    next_cycle();
`else
    #3;
    chk32("nowd_never_granted", granted_at, 0);
    chk1("nowd_lock_err", lock_err, F);
    chk1("nowd_cpu_holds", dbg_state == ST_OWN0, T);
    set_m0(F, F, 0, 0, F);
    next_cycle();
    next_cycle();
    #3; chk1("nowd_release_ready1", m1_if.ready, T);
    set_m1(F, F, 0, 0, F);
    next_cycle();
    next_cycle();
`endif

    // ---------------- reset with a read in flight ----------------
    rst = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    #3; chk1("rst2_lock_err_clear", lock_err, F);
    next_cycle();
    set_m0(T, F, 'h700, 0, F);
    next_cycle();
    #3; chk1("rst2_accept_ready0", m0_if.ready, T);
    next_cycle();
    set_m0(F, F, 0, 0, F);
    rst = 1'b0;
    #3;
    chk_out("rst2_during_outputs", cur_out(), zero_out);
    chk1("rst2_during_state", dbg_state == ST_IDLE, T);
    next_cycle();
    mem_rdata = 'hDEAD_0000;
    #3; chk_out("rst2_no_rvalid", cur_out(), zero_out);
    next_cycle();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #3; chk_out($sformatf("rst2_after_%0d", k), cur_out(), zero_out);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
